// File: rtl/aes_subbytes_enc.sv
// aes_subbytes_enc: word-serial AES SubBytes engine, four byte lanes sharing one S-box table.
// Define AES_SUBBYTES_INV_EN to add the inverse port and inverse table.
module aes_subbytes_enc #(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef AES_SUBBYTES_INV_EN
  input  logic         inverse,
`endif
  input  logic [127:0] block_in,
  output logic         ready,
  output logic         result_valid,
  output logic [127:0] block_out
);
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
`ifdef AES_SUBBYTES_INV_EN
  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  logic inv_q, inv_n;
`endif
  typedef enum logic {IDLE, SUB} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n, idx;
  logic [31:0] cur, sub_w;
  logic [127:0] blk_n;
  logic rdy_n, vld_n;
  // entry b sits at bits 2047-8b downto 2040-8b of the packed table
  assign idx = MSW_FIRST ? ~cnt : cnt;
  assign cur = block_out[{idx, 5'b0} +: 32];
  always_comb begin
    sub_w = '0;
    for (int i = 0; i < 4; i++)
`ifdef AES_SUBBYTES_INV_EN
      sub_w[8*i +: 8] = inv_q ? INV[{~cur[8*i +: 8], 3'b111} -: 8] : FWD[{~cur[8*i +: 8], 3'b111} -: 8];
`else
      sub_w[8*i +: 8] = FWD[{~cur[8*i +: 8], 3'b111} -: 8];
`endif
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    blk_n = block_out;
    rdy_n = ready;
    vld_n = result_valid;
`ifdef AES_SUBBYTES_INV_EN
    inv_n = inv_q;
`endif
    if (state == IDLE) begin
      if (start) begin
        state_n = SUB;
        cnt_n = '0;
        blk_n = block_in;
        rdy_n = 1'b0;
        vld_n = 1'b0;
`ifdef AES_SUBBYTES_INV_EN
        inv_n = inverse;
`endif
      end
    end else begin
      blk_n[{idx, 5'b0} +: 32] = sub_w;
      cnt_n = cnt + 2'd1;
      state_n = cnt == 2'd3 ? IDLE : SUB;
      rdy_n = cnt == 2'd3;
      vld_n = cnt == 2'd3;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      block_out <= '0;
      ready <= 1'b1;
      result_valid <= 1'b0;
`ifdef AES_SUBBYTES_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      block_out <= blk_n;
      ready <= rdy_n;
      result_valid <= vld_n;
`ifdef AES_SUBBYTES_INV_EN
      inv_q <= inv_n;
`endif
    end
  end
endmodule

// File: tb/tb_aes_subbytes_enc.sv
// tb_aes_subbytes_enc: directed checks of both word orders against hand-computed S-box results.
module tb_aes_subbytes_enc;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [127:0] block_in = '0;
  logic rdy_m, vld_m, rdy_l, vld_l;
  logic [127:0] bo_m, bo_l;
  int checks = 0, failures = 0;
  localparam logic [127:0] V = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] F = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
`ifdef AES_SUBBYTES_INV_EN
  logic inverse = 1'b0;
`endif
  always #5 clk = ~clk;
  aes_subbytes_enc #(.MSW_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .start(start),
`ifdef AES_SUBBYTES_INV_EN
    .inverse(inverse),
`endif
    .block_in(block_in), .ready(rdy_m), .result_valid(vld_m), .block_out(bo_m));
  aes_subbytes_enc #(.MSW_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .start(start),
`ifdef AES_SUBBYTES_INV_EN
    .inverse(inverse),
`endif
    .block_in(block_in), .ready(rdy_l), .result_valid(vld_l), .block_out(bo_l));

  task automatic test_reset(input string tag);
    checks++; if (rdy_m !== 1'b1) begin failures++; $display("FAIL %s ready_msw got=%b want=1", tag, rdy_m); end
    checks++; if (vld_m !== 1'b0) begin failures++; $display("FAIL %s valid_msw got=%b want=0", tag, vld_m); end
    checks++; if (bo_m !== 128'h0) begin failures++; $display("FAIL %s block_out_msw got=%h want=0", tag, bo_m); end
    checks++; if (rdy_l !== 1'b1) begin failures++; $display("FAIL %s ready_lsw got=%b want=1", tag, rdy_l); end
    checks++; if (vld_l !== 1'b0) begin failures++; $display("FAIL %s valid_lsw got=%b want=0", tag, vld_l); end
    checks++; if (bo_l !== 128'h0) begin failures++; $display("FAIL %s block_out_lsw got=%h want=0", tag, bo_l); end
  endtask

  task automatic test_zero();
    @(negedge clk); block_in = '0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    checks++; if (rdy_m !== 1'b0) begin failures++; $display("FAIL zero_accept ready got=%b want=0", rdy_m); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (vld_m !== 1'b0) begin failures++; $display("FAIL zero_early valid got=%b want=0", vld_m); end
    @(posedge clk); @(negedge clk);
    checks++; if (bo_m !== {16{8'h63}}) begin failures++; $display("FAIL zero_msw block_out got=%h want=%h", bo_m, {16{8'h63}}); end
    checks++; if (bo_l !== {16{8'h63}}) begin failures++; $display("FAIL zero_lsw block_out got=%h want=%h", bo_l, {16{8'h63}}); end
    checks++; if (vld_m !== 1'b1 || rdy_m !== 1'b1) begin failures++; $display("FAIL zero_done valid/ready got=%b%b want=11", vld_m, rdy_m); end
    checks++; if (vld_l !== 1'b1 || rdy_l !== 1'b1) begin failures++; $display("FAIL zero_done_lsw valid/ready got=%b%b want=11", vld_l, rdy_l); end
  endtask

  task automatic test_vector_ignore();
    start = 1'b1; block_in = V;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (bo_m !== {32'h638293c3, V[95:0]}) begin failures++; $display("FAIL vec_first_msw got=%h want=%h", bo_m, {32'h638293c3, V[95:0]}); end
    checks++; if (bo_l !== {V[127:32], 32'h4bc12816}) begin failures++; $display("FAIL vec_first_lsw got=%h want=%h", bo_l, {V[127:32], 32'h4bc12816}); end
    start = 1'b1; block_in = '1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bo_m !== F) begin failures++; $display("FAIL vec_final_msw got=%h want=%h", bo_m, F); end
    checks++; if (bo_l !== F) begin failures++; $display("FAIL vec_final_lsw got=%h want=%h", bo_l, F); end
    checks++; if (vld_m !== 1'b1) begin failures++; $display("FAIL vec_valid got=%b want=1", vld_m); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; block_in = {16{8'h01}};
    @(posedge clk); @(negedge clk); start = 1'b0;
    checks++; if (vld_m !== 1'b0) begin failures++; $display("FAIL b2b_drop valid got=%b want=0", vld_m); end
    checks++; if (rdy_l !== 1'b0) begin failures++; $display("FAIL b2b_drop ready_lsw got=%b want=0", rdy_l); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (bo_m !== {16{8'h7c}}) begin failures++; $display("FAIL b2b_msw got=%h want=%h", bo_m, {16{8'h7c}}); end
    checks++; if (bo_l !== {16{8'h7c}}) begin failures++; $display("FAIL b2b_lsw got=%h want=%h", bo_l, {16{8'h7c}}); end
    checks++; if (vld_l !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b want=1", vld_l); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1; block_in = V;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1 test_reset("reset_mid");
    @(negedge clk); reset = 1'b0;
  endtask

`ifdef AES_SUBBYTES_INV_EN
  task automatic test_inverse();
    @(negedge clk); start = 1'b1; block_in = F; inverse = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0; inverse = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (bo_m !== V) begin failures++; $display("FAIL inv_msw got=%h want=%h", bo_m, V); end
    checks++; if (bo_l !== V) begin failures++; $display("FAIL inv_lsw got=%h want=%h", bo_l, V); end
  endtask
`endif

  initial begin
    #1 reset = 1'b1;
    #1 test_reset("reset_init");
    @(negedge clk); reset = 1'b0;
    test_zero();
    test_vector_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_SUBBYTES_INV_EN
    test_inverse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_subbytes_enc.md
Name: aes_subbytes_enc

Overview:
- Sequential forward SubBytes engine for the encipher datapath.
- Applies the FIPS-197 forward S-box to a 128-bit state, one 32-bit word per cycle, through a single 4-lane forward S-box.
- Four lanes share one table, so area stays at one word of S-box logic.
- Sits between the AddRoundKey and ShiftRows stages of the encipher round; start/ready/valid handshake to the round controller.

Parameters:
- MSW_FIRST, 1, word processing order. 1: bits 127:96 first, down to 31:0. 0: bits 31:0 first, up to 127:96.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to substitute block_in; accepted only when ready=1.
- block_in  in  128  state to substitute; sampled on the accepting edge only.
- ready  out  1  engine idle, can accept start.
- result_valid  out  1  block_out holds a complete substituted state.
- block_out  out  128  working/result state register.

Behaviour:
- Reset (async, active-high), all outputs in the same instant:
  - FSM=IDLE, word counter=0.
  - block_out=128'h0, ready=1, result_valid=0.
- Reset mid-operation aborts the operation and returns to the reset values above; nothing partial is retained.
- Forward S-box: 256-entry constant table, exact inverse of the team's existing inverse S-box. Combinational per byte, four identical byte lanes.
- FSM states: IDLE, SUB.
- IDLE:
  - start=1 at an edge: block_out<=block_in, counter<=0, ready<=0, result_valid<=0, go to SUB.
  - Otherwise hold block_out and result_valid.
- SUB: each edge replaces word[counter] of block_out with sbox4(word[counter]) and increments counter.
  - Word mapping with MSW_FIRST=1: counter 0 = bits 127:96 … counter 3 = bits 31:0. MSW_FIRST=0 mirrors this.
  - On the edge processing counter=3: counter<=0, ready<=1, result_valid<=1, go to IDLE.
- Latency: start accepted at edge T0; result_valid=1 and ready=1 after edge T4 (4 SUB cycles). Throughput is one block per 5 cycles including the accept edge.
- start while ready=0 is ignored, with no queueing; block_in changes during SUB have no effect.
- start on the same edge that result_valid is high: accepted normally; result_valid clears on that edge.
- result_valid stays high until the next accepted start or reset.
- Counter is 2 bits; wrap from 3 to 0 coincides with the transition to IDLE.
- Intermediate block_out values during SUB are visible but have no meaning while result_valid=0.

Optional Feature:
- Macro AES_SUBBYTES_INV_EN.
- Defined:
  - Adds input port "inverse" (1 bit), sampled on the accepting edge and held internally for the whole operation.
  - inverse=1 selects the inverse S-box table for all four lanes, so one engine serves both encipher and decipher.
  - Latency and handshake are unchanged.
- Undefined:
  - No inverse port and no inverse table logic.
  - Forward-only operation.

Test Plan:
- Reset → ready=1, result_valid=0, block_out=0. Assert reset again mid-SUB (after 2 words) → same values immediately, with no clk edge required.
- block_in=0, start pulse → after exactly 4 further edges block_out=63636363_63636363_63636363_63636363, result_valid=1, ready=1.
- block_in=00112233_44556677_8899aabb_ccddeeff, MSW_FIRST=1:
  - After the first SUB edge, block_out[127:96]=638293c3 and the lower 96 bits are unchanged.
  - Final block_out=638293c3_1bfc33f5_c4eeacea_4bc12816.
- Same vector with MSW_FIRST=0 → after the first SUB edge only bits 31:0 are substituted (4bc12816); the final result is identical.
- Second start pulsed during SUB with block_in=ffffffff… → ignored; the result is still the first block's. Then start with result_valid=1 and block_in=all 01 → result_valid drops on that edge; 4 edges later block_out=7c7c…7c.
- AES_SUBBYTES_INV_EN defined, inverse=1, block_in=638293c3_1bfc33f5_c4eeacea_4bc12816 → block_out=00112233_44556677_8899aabb_ccddeeff after 4 edges.
